// File: rtl/abz_pkg.sv
// Shared ABZ definitions: FSM states, quadrature phase encoding and direction codes.
`default_nettype none

package abz_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef logic [1:0] phase_t;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  // {A,B} per phase, packed ph3..ph0 = 01,11,10,00
  localparam logic [7:0] PHASE_AB = 8'b01_11_10_00;

  function automatic logic [1:0] phase_ab(input phase_t p);
    return PHASE_AB[{p, 1'b0} +: 2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/abz_rate_div.sv
// Loadable down-counter emitting a one-cycle tick every (period_m1+1) enabled cycles.
`default_nettype none

module abz_rate_div #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             load,
  input  logic [DIV_W-1:0] period_m1,
  input  logic             en,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] reload;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt    <= '0;
      reload <= '0;
    end else if (load) begin
      cnt    <= period_m1;
      reload <= period_m1;
    end else if (en) begin
      cnt <= (cnt == '0) ? reload : cnt - 1'b1;
    end
  end

  assign tick = en && (cnt == '0);

endmodule

`default_nettype wire

// File: rtl/abz_generator.sv
// Quadrature A/B/Z encoder emulator; the index path (POS, Z) exists only when
// ABZ_GEN_INDEX_EN is defined, otherwise POS and Z are tied to 0.
`default_nettype none

module abz_generator
  import abz_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int DIV_W = 16,
  parameter int PPR   = 1024
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_dir,
  input  logic [CNT_W-1:0]           cmd_edges,
  input  logic [DIV_W-1:0]           cmd_div,
  input  logic                       abort,
  output logic                       a,
  output logic                       b,
  output logic                       z,
  output logic [$clog2(4*PPR)-1:0]   pos,
  output logic                       busy,
  output logic                       done
);

  localparam int POS_W = $clog2(4*PPR);

  state_t           state, state_next;
  logic             dir;
  logic [CNT_W-1:0] remaining;
  phase_t           ph, ph_next;
  logic             accept;
  logic [DIV_W-1:0] div_eff;
  logic             tick;
  logic             step;

  assign accept  = cmd_valid && cmd_ready;
  assign div_eff = (cmd_div == '0) ? DIV_W'(1) : cmd_div;
  // Abort wins over a coincident tick: the edge is dropped.
  assign step    = (state == ST_RUN) && tick && !abort;
  assign ph_next = (dir == DIR_REV) ? ph - 2'd1 : ph + 2'd1;

  abz_rate_div #(
    .DIV_W(DIV_W)
  ) u_rate_div (
    .clk      (clk),
    .arst     (arst),
    .load     (accept),
    .period_m1(div_eff - 1'b1),
    .en       (state == ST_RUN),
    .tick     (tick)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = (cmd_edges == '0) ? ST_DONE : ST_RUN;
      ST_RUN: begin
        if (abort)                                 state_next = ST_IDLE;
        else if (step && remaining == CNT_W'(1))   state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == ST_IDLE);
    busy      = (state == ST_RUN);
    done      = (state == ST_DONE);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      dir       <= DIR_FWD;
      remaining <= '0;
      ph        <= '0;
      a         <= 1'b0;
      b         <= 1'b0;
    end else if (accept) begin
      dir       <= cmd_dir;
      remaining <= cmd_edges;
    end else if (step) begin
      remaining <= remaining - 1'b1;
      ph        <= ph_next;
      {a, b}    <= phase_ab(ph_next);
    end
  end

`ifdef ABZ_GEN_INDEX_EN
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(4*PPR - 1);

  logic [POS_W-1:0] pos_q;
  logic [POS_W-1:0] pos_next;
  logic             z_q;

  always_comb begin
    if (dir == DIR_REV) pos_next = (pos_q == '0) ? POS_MAX : pos_q - 1'b1;
    else                pos_next = (pos_q == POS_MAX) ? '0 : pos_q + 1'b1;
  end

  // Z is registered alongside A/B so the index pulse lines up with the edge.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      pos_q <= '0;
      z_q   <= 1'b1;
    end else if (step) begin
      pos_q <= pos_next;
      z_q   <= (pos_next == '0);
    end
  end

  assign pos = pos_q;
  assign z   = z_q;
`else
  assign pos = '0;
  assign z   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_abz_generator.sv
// Directed self-checking bench for abz_generator (PPR=1024 instance and PPR=1 instance).
`default_nettype none

module tb_abz_generator;

`ifdef ABZ_GEN_INDEX_EN
  localparam bit IDX = 1'b1;
`else
  localparam bit IDX = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, valid, valid1, dir, abort;
  logic [15:0] edges, div;

  logic        ready, a, b, z, busy, done;
  logic [11:0] pos;
  logic        ready1, a1, b1, z1, busy1, done1;
  logic [1:0]  pos1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  abz_generator #(.CNT_W(16), .DIV_W(16), .PPR(1024)) dut (
    .clk(clk), .arst(rst), .cmd_valid(valid), .cmd_ready(ready), .cmd_dir(dir),
    .cmd_edges(edges), .cmd_div(div), .abort(abort), .a(a), .b(b), .z(z),
    .pos(pos), .busy(busy), .done(done)
  );

  abz_generator #(.CNT_W(16), .DIV_W(16), .PPR(1)) dut1 (
    .clk(clk), .arst(rst), .cmd_valid(valid1), .cmd_ready(ready1), .cmd_dir(dir),
    .cmd_edges(edges), .cmd_div(div), .abort(abort), .a(a1), .b(b1), .z(z1),
    .pos(pos1), .busy(busy1), .done(done1)
  );

  function automatic logic [1:0] ab_of(input logic [1:0] p);
    case (p)
      2'd0:    return 2'b00;
      2'd1:    return 2'b10;
      2'd2:    return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  // Called 1ns after a posedge; returns 1ns after the acceptance edge.
  task automatic send(input logic d, input logic [15:0] e, input logic [15:0] v, input logic to1);
    dir = d; edges = e; div = v;
    if (to1) valid1 = 1'b1; else valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0; valid1 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({a, b} !== 2'b00) begin failures++; $display("FAIL reset_ab got=%b exp=00", {a, b}); end
    checks++; if (z !== IDX) begin failures++; $display("FAIL reset_z got=%b exp=%b", z, IDX); end
    checks++; if ({busy, done, ready} !== 3'b001) begin failures++; $display("FAIL reset_ctl got=%b exp=001", {busy, done, ready}); end
    send(1'b0, 16'd8, 16'd3, 1'b0);
    repeat (4) @(posedge clk);
    checks++; if ({a, b, busy} !== 3'b101) begin failures++; $display("FAIL prerst_run got=%b exp=101", {a, b, busy}); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({a, b, z, busy} !== {2'b00, IDX, 1'b0}) begin failures++; $display("FAIL midrst_out got=%b exp=%b", {a, b, z, busy}, {2'b00, IDX, 1'b0}); end
    checks++; if (pos !== 12'd0) begin failures++; $display("FAIL midrst_pos got=%0d exp=0", pos); end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++; if ({ready, busy} !== 2'b10) begin failures++; $display("FAIL postrst_ready got=%b exp=10", {ready, busy}); end
  endtask

  task automatic test_fwd8();
    logic [1:0] ph = 2'd0;
    do_reset();
    send(1'b0, 16'd8, 16'd3, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      repeat (2) @(posedge clk); #1;
      checks++; if ({a, b} !== ab_of(ph)) begin failures++; $display("FAIL fwd8_hold%0d got=%b exp=%b", k, {a, b}, ab_of(ph)); end
      @(posedge clk); #1;
      ph = ph + 2'd1;
      checks++; if ({a, b} !== ab_of(ph)) begin failures++; $display("FAIL fwd8_edge%0d got=%b exp=%b", k, {a, b}, ab_of(ph)); end
      checks++; if (pos !== (IDX ? 12'(k) : 12'd0)) begin failures++; $display("FAIL fwd8_pos%0d got=%0d", k, pos); end
      checks++; if (z !== 1'b0) begin failures++; $display("FAIL fwd8_z%0d got=%b exp=0", k, z); end
      checks++; if ({done, busy} !== ((k == 8) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL fwd8_status%0d got=%b", k, {done, busy}); end
    end
    @(posedge clk); #1;
    checks++; if ({done, ready} !== 2'b01) begin failures++; $display("FAIL fwd8_after got=%b exp=01", {done, ready}); end
  endtask

  task automatic test_rev_wrap();
    do_reset();
    checks++; if (z !== IDX) begin failures++; $display("FAIL rev_z_before got=%b exp=%b", z, IDX); end
    send(1'b1, 16'd1, 16'd0, 1'b0);
    @(posedge clk); #1;
    checks++; if ({a, b} !== 2'b01) begin failures++; $display("FAIL rev_ab got=%b exp=01", {a, b}); end
    checks++; if (pos !== (IDX ? 12'd4095 : 12'd0)) begin failures++; $display("FAIL rev_pos got=%0d", pos); end
    checks++; if ({z, done} !== 2'b01) begin failures++; $display("FAIL rev_z_done got=%b exp=01", {z, done}); end
  endtask

  task automatic test_index_ppr1();
    logic [1:0] ph = 2'd0;
    do_reset();
    send(1'b0, 16'd8, 16'd1, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      ph = ph + 2'd1;
      checks++; if ({a1, b1} !== ab_of(ph)) begin failures++; $display("FAIL ppr1_ab%0d got=%b exp=%b", k, {a1, b1}, ab_of(ph)); end
      checks++; if (pos1 !== (IDX ? ph : 2'd0)) begin failures++; $display("FAIL ppr1_pos%0d got=%0d", k, pos1); end
      checks++; if (z1 !== (IDX && ph == 2'd0)) begin failures++; $display("FAIL ppr1_z%0d got=%b", k, z1); end
    end
    checks++; if (done1 !== 1'b1) begin failures++; $display("FAIL ppr1_done got=%b exp=1", done1); end
  endtask

  task automatic test_abort();
    do_reset();
    send(1'b0, 16'd10, 16'd2, 1'b0);
    repeat (6) @(posedge clk); #1;
    checks++; if ({a, b} !== 2'b01) begin failures++; $display("FAIL abort_pre_ab got=%b exp=01", {a, b}); end
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    checks++; if ({busy, done, ready} !== 3'b001) begin failures++; $display("FAIL abort_ctl got=%b exp=001", {busy, done, ready}); end
    repeat (3) begin
      @(posedge clk); #1;
      checks++; if ({a, b, done} !== 3'b010) begin failures++; $display("FAIL abort_hold got=%b exp=010", {a, b, done}); end
    end
    checks++; if (pos !== (IDX ? 12'd3 : 12'd0)) begin failures++; $display("FAIL abort_pos got=%0d", pos); end
    send(1'b0, 16'd10, 16'd2, 1'b0);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    checks++; if ({a, b} !== 2'b01) begin failures++; $display("FAIL abort_tick_ab got=%b exp=01", {a, b}); end
    checks++; if ({busy, done, ready} !== 3'b001) begin failures++; $display("FAIL abort_tick_ctl got=%b exp=001", {busy, done, ready}); end
    checks++; if (pos !== (IDX ? 12'd3 : 12'd0)) begin failures++; $display("FAIL abort_tick_pos got=%0d", pos); end
  endtask

  task automatic test_zero_edges();
    send(1'b0, 16'd0, 16'd5, 1'b0);
    checks++; if ({done, busy, ready} !== 3'b100) begin failures++; $display("FAIL zero_done got=%b exp=100", {done, busy, ready}); end
    checks++; if ({a, b} !== 2'b01) begin failures++; $display("FAIL zero_ab got=%b exp=01", {a, b}); end
    @(posedge clk); #1;
    checks++; if ({done, ready} !== 2'b01) begin failures++; $display("FAIL zero_after got=%b exp=01", {done, ready}); end
    checks++; if (pos !== (IDX ? 12'd3 : 12'd0)) begin failures++; $display("FAIL zero_pos got=%0d", pos); end
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; valid1 = 1'b0; dir = 1'b0; abort = 1'b0;
    edges = '0; div = '0;
    test_reset();
    test_fwd8();
    test_rev_wrap();
    test_index_ppr1();
    test_abort();
    test_zero_edges();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
